// File: rtl/fft_result_unloader.sv
// Drains the final FFT bank in natural frequency order as a valid/ready stream of complex samples.
// A 4-entry skid buffer absorbs the 1-cycle synchronous RAM latency, and credit-gated reads prevent it from overflowing.
module fft_result_unloader #(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 8,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_bank_sel,
    output logic                    o_rd_en,
    output logic                    o_rd_bank,
    output logic [$clog2(N)-1:0]    o_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] i_rd_data,
    output logic                    o_m_valid,
    input  logic                    i_m_ready,
    output logic [DATA_WIDTH-1:0]   o_m_re,
    output logic [DATA_WIDTH-1:0]   o_m_im,
    output logic [$clog2(N)-1:0]    o_m_index,
    output logic                    o_m_last,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int AW  = $clog2(N);
    localparam int DW2 = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t          r_state;
    logic            r_rd_en;
    logic            r_rd_bank;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   r_rd_idx;
    logic [AW-1:0]   r_out_idx;
    logic            r_pend;
    logic            r_done;
    logic [DW2-1:0]  r_mem [4];
    logic [1:0]      r_wptr;
    logic [1:0]      r_rptr;
    logic [2:0]      r_count;

    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;
    logic            w_accept;
    logic [3:0]      w_reserved;

    function automatic logic [AW-1:0] f_addr(input logic [AW-1:0] idx);
        logic [AW-1:0] rev;
        rev = '0;
        for (int b = 0; b < AW; b++) begin
            rev[b] = idx[AW-1-b];
        end
        return BIT_REVERSE ? rev : idx;
    endfunction

    assign w_valid    = (r_count != 3'd0);
    assign w_push     = r_pend;
    assign w_pop      = w_valid & i_m_ready;
    assign w_accept   = (r_state == S_IDLE) & i_start;
    // Slots are reserved for buffered data plus every read still in the RAM pipe; a pop only frees a slot next cycle.
    assign w_reserved = {1'b0, r_count} + {3'b000, r_pend} + {3'b000, r_rd_en};
    assign w_credit   = (w_reserved < 4'd4);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_rd_data;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_addr <= '0;
            r_rd_idx  <= '0;
            r_out_idx <= '0;
            r_pend    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_pend  <= r_rd_en;
            if (w_pop) begin
                r_out_idx <= r_out_idx + AW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_ISSUE;
                        r_rd_bank <= i_bank_sel;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= f_addr('0);
                        r_rd_idx  <= AW'(1);
                        r_out_idx <= '0;
                        r_pend    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (w_credit) begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= f_addr(r_rd_idx);
                        r_rd_idx  <= r_rd_idx + AW'(1);
                        if (r_rd_idx == AW'(N - 1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && (r_out_idx == AW'(N - 1))) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_en   = r_rd_en;
    assign o_rd_bank = r_rd_bank;
    assign o_rd_addr = r_rd_addr;
    assign o_m_valid = w_valid;
    assign o_m_re    = r_mem[r_rptr][DW2-1:DATA_WIDTH];
    assign o_m_im    = r_mem[r_rptr][DATA_WIDTH-1:0];
    assign o_m_index = r_out_idx;
    assign o_m_last  = w_valid & (r_out_idx == AW'(N - 1));
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = r_done;

endmodule

// File: doc/fft_result_unloader.md
Name: fft_result_unloader

Overview:
- Reads the final FFT results out of the ping-pong bank that holds the last stage's output, in natural frequency order.
- Emits the results as a valid/ready stream of complex samples, so downstream logic (host interface, magnitude unit) can drain them.
- Undoes the address ordering left by the in-place decimation.
- Absorbs the 1-cycle synchronous RAM read latency with an internal 4-entry skid buffer, sustaining 1 sample/cycle when the sink is always ready.

Parameters:
- DATA_WIDTH, 16, width of each of re and im.
- N, 8, FFT points; power of two, ≥4.
- BIT_REVERSE, 1: 1 = read address is the bit-reversal of the output index; 0 = read address equals the index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; final stage written, begin unloading.
- bank_sel  in  1  bank holding the results (0 = mem0, 1 = mem1); sampled only when start is accepted.
- rd_en  out  1  read strobe to the selected bank.
- rd_bank  out  1  latched bank_sel.
- rd_addr  out  $clog2(N)  bank read address.
- rd_data  in  2*DATA_WIDTH  {re,im}; valid the cycle after rd_en.
- m_valid  out  1  output sample valid.
- m_ready  in  1  sink accepts.
- m_re  out  DATA_WIDTH  real part.
- m_im  out  DATA_WIDTH  imaginary part.
- m_index  out  $clog2(N)  frequency bin of the current sample.
- m_last  out  1  high with bin N-1.
- busy  out  1  unload in progress.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: rd_en=0, rd_bank=0, rd_addr=0, m_valid=0, m_re=0, m_im=0, m_index=0, m_last=0, busy=0, done=0. The buffer is emptied and in-flight reads are discarded.
- Reset mid-unload: same as above. No further rd_en, no done.
- States:
  - IDLE: busy=0. start=1 → ISSUE; latch bank_sel; clear issue counter rd_idx, output counter out_idx, buffer.
  - ISSUE: busy=1. rd_en=1 when credit holds, rd_addr = BIT_REVERSE ? bitrev(rd_idx) : rd_idx. rd_idx increments per issued read. After the read with rd_idx=N-1 is issued → DRAIN.
  - DRAIN: busy=1, no reads. On the handshake of out_idx=N-1 → IDLE with done=1 for the following cycle; busy drops in that same cycle.
- Credit rule: issue only if occupancy + inflight < 4. inflight (0..2) counts reads issued but not yet pushed. A pop in the current cycle does not free credit until the next cycle.
- Read pipeline:
  - Read issued in cycle t.
  - rd_data sampled during cycle t+1, pushed into the buffer at the end of t+1.
  - Visible on m_* from cycle t+2.
  - Latency from the start cycle to the first m_valid is 3 cycles.
- Handshake:
  - Transfer occurs when m_valid & m_ready.
  - m_re/m_im/m_index/m_last hold stable while m_valid & ~m_ready.
  - m_valid never drops without a transfer.
  - m_index = out_idx; out_idx increments per transfer.
- Throughput: m_ready held high → N transfers in N consecutive cycles. Under backpressure, reads stall once the buffer would overflow; no data is lost or duplicated.
- Simultaneous push and pop: occupancy unchanged. Pop on empty is impossible because m_valid=0.
- Start while busy: ignored, and bank_sel is not re-sampled. Start in the same cycle as done: accepted; the new unload begins next cycle.
- Data passes through unmodified. No scaling or rounding; bits [2*DATA_WIDTH-1:DATA_WIDTH] are re.
- Counters are $clog2(N) wide with no wrap past N-1 within an unload.

Test Plan:
- Model bank word[a] = {16'h0100+a, 16'h0200+a}, m_ready=1, BIT_REVERSE=1, start pulse at cycle 0 → m_valid first at cycle 3.
  - 8 consecutive transfers, m_re = 0100,0104,0102,0106,0101,0105,0103,0107.
  - m_im = 0200+bitrev(idx).
  - m_last only on idx 7; done at cycle 11; busy low at cycle 11.
- Same stimulus with BIT_REVERSE=0 → m_re = 0100..0107 in order.
- bank_sel=1 at start, toggled to 0 the cycle after → rd_bank=1 for all 8 reads.
- m_ready low for cycles 3–9, then high → at most 4 buffered plus stalled reads; m_re=0100 held stable through cycle 9; all 8 samples delivered in order with no duplicates.
- Random m_ready (50%) over 20 unloads → scoreboard matches, exactly one done per unload.
- start again at cycle 5 while busy → ignored, single done. rst asserted at cycle 6 → all outputs zero at cycle 7; subsequent start produces a clean full unload.
